// File: rtl/irq_ctrl_if.sv
// CPU data/instruction bus as seen by a memory-mapped responder.
// Signal names carry the responder's direction (i_ = into responder).
interface irq_ctrl_if;
   logic [15:0] i_mem_addr;
   logic [15:0] i_mem_write_data;
   logic        i_ram_we;
   logic [15:0] o_rdata;
   logic        o_sel;

   modport master (
      output i_mem_addr, i_mem_write_data, i_ram_we,
      input  o_rdata, o_sel
   );

   modport slave (
      input  i_mem_addr, i_mem_write_data, i_ram_we,
      output o_rdata, o_sel
   );
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronizes NSRC sources, latches them
// as pending (edge or level), and drives a prioritized request + vector to the CPU.
module irq_ctrl #(
   parameter int unsigned NSRC        = 8,
   parameter logic [15:0] BASE        = 16'hFF00,
   parameter int unsigned VEC_STRIDE  = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ce,
   irq_ctrl_if.slave        bus,
   input  logic [NSRC-1:0]  i_src,
   output logic             o_int,
   output logic [15:0]      o_int_addr
);
   localparam logic [15:0] VBASE_RST   = 16'h2100;
   localparam logic [15:0] OFF_PENDING = 16'd0;
   localparam logic [15:0] OFF_ENABLE  = 16'd1;
   localparam logic [15:0] OFF_MODE    = 16'd2;
   localparam logic [15:0] OFF_VBASE   = 16'd3;
   localparam logic [15:0] OFF_ACTIVE  = 16'd4;
   localparam logic [15:0] OFF_SWSET   = 16'd5;
   localparam logic [15:0] NUM_REGS    = 16'd6;

   logic [SYNC_STAGES-1:0][NSRC-1:0] r_sync;
   logic [NSRC-1:0] r_s_d;
   logic [NSRC-1:0] r_pending;
   logic [NSRC-1:0] r_enable;
   logic [NSRC-1:0] r_mode;
   logic [15:0]     r_vbase;

   logic [NSRC-1:0] w_s;
   logic [15:0]     w_off;
   logic            w_hit;
   logic            w_wr;
   logic [NSRC-1:0] w_wmask;
   logic [NSRC-1:0] w_w1c;
   logic [NSRC-1:0] w_swset;
   logic [NSRC-1:0] w_set;
   logic [NSRC-1:0] w_pend_nxt;
   logic [NSRC-1:0] w_act;
   logic            w_any;
   logic [3:0]      w_id;
   logic [15:0]     w_vec;
   logic [15:0]     w_rd;

   assign w_s     = r_sync[SYNC_STAGES-1];
   assign w_off   = bus.i_mem_addr - BASE;
   assign w_hit   = (w_off < NUM_REGS);
   assign w_wr    = bus.i_ram_we & w_hit;
   assign w_wmask = bus.i_mem_write_data[NSRC-1:0];
   assign w_w1c   = (w_wr && (w_off == OFF_PENDING)) ? w_wmask : '0;
   assign w_swset = (w_wr && (w_off == OFF_SWSET))   ? w_wmask : '0;

   // Edge bits: set (rise or SWSET) beats W1C. Level bits follow the synced input.
   assign w_set      = (w_s & ~r_s_d) | w_swset;
   assign w_pend_nxt = (r_mode & ((r_pending & ~w_w1c) | w_set)) | (~r_mode & w_s);

   assign w_act = r_pending & r_enable;
   assign w_any = |w_act;
   assign w_vec = r_vbase + 16'(w_id) * 16'(VEC_STRIDE);

   // Lowest active index wins.
   always_comb begin
      w_id = 4'd0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (w_act[i]) w_id = 4'(i);
      end
   end

   always_comb begin
      w_rd = 16'h0000;
      case (w_off)
         OFF_PENDING: w_rd = 16'(r_pending);
         OFF_ENABLE:  w_rd = 16'(r_enable);
         OFF_MODE:    w_rd = 16'(r_mode);
         OFF_VBASE:   w_rd = r_vbase;
         OFF_ACTIVE:  w_rd = {w_any, 11'd0, w_id};
         default:     w_rd = 16'h0000;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_sync      <= '0;
         r_s_d       <= '0;
         r_pending   <= '0;
         r_enable    <= '0;
         r_mode      <= '0;
         r_vbase     <= VBASE_RST;
         o_int       <= 1'b0;
         o_int_addr  <= 16'h0000;
         bus.o_rdata <= 16'h0000;
         bus.o_sel   <= 1'b0;
      end else if (i_ce) begin
         r_sync[0] <= i_src;
         for (int k = 1; k < int'(SYNC_STAGES); k++) r_sync[k] <= r_sync[k-1];
         r_s_d     <= w_s;
         r_pending <= w_pend_nxt;

         if (w_wr) begin
            case (w_off)
               OFF_ENABLE: r_enable <= w_wmask;
               OFF_MODE:   r_mode   <= w_wmask;
               OFF_VBASE:  r_vbase  <= bus.i_mem_write_data;
               default:    ;
            endcase
         end

         o_int <= w_any;
         if (w_any) o_int_addr <= w_vec;

         bus.o_rdata <= w_hit ? w_rd : 16'h0000;
         bus.o_sel   <= w_hit;
      end
   end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed + randomized bench for irq_ctrl against a queue-based behavioural model.
module tb_irq_ctrl;
   localparam int unsigned NSRC   = 8;
   localparam logic [15:0] BASE   = 16'hFF00;
   localparam int unsigned STRIDE = 4;
   localparam int unsigned SS     = 2;

   logic            i_clk;
   logic            i_rst;
   logic            i_ce;
   logic [NSRC-1:0] i_src;
   logic            o_int;
   logic [15:0]     o_int_addr;

   irq_ctrl_if bus();

   irq_ctrl #(.NSRC(NSRC), .BASE(BASE), .VEC_STRIDE(STRIDE), .SYNC_STAGES(SS)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .bus(bus),
      .i_src(i_src), .o_int(o_int), .o_int_addr(o_int_addr)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_err = 0;

   // Model: input history queue (index 0 = most recent enabled-edge sample).
   logic [NSRC-1:0] m_hist[$];
   logic [NSRC-1:0] m_pend, m_en, m_mode;
   logic [15:0]     m_vbase, m_int_addr, m_rdata;
   logic            m_int, m_sel;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [NSRC-1:0] s, sd, np;
      logic [15:0] off, wd, rv;
      logic hit, wr, any;
      int id;
      if (!i_rst) begin
         m_pend = '0; m_en = '0; m_mode = '0; m_vbase = 16'h2100;
         m_int = 1'b0; m_int_addr = 16'h0; m_rdata = 16'h0; m_sel = 1'b0;
         m_hist = {};
         for (int k = 0; k <= int'(SS); k++) m_hist.push_front('0);
      end else if (i_ce) begin
         s   = m_hist[SS-1];
         sd  = m_hist[SS];
         off = bus.i_mem_addr - BASE;
         wd  = bus.i_mem_write_data;
         hit = (off < 16'd6);
         wr  = bus.i_ram_we && hit;
         any = 1'b0; id = 0;
         for (int i = 0; i < int'(NSRC); i++)
            if (!any && m_pend[i] && m_en[i]) begin any = 1'b1; id = i; end
         case (off)
            16'd0:   rv = 16'(m_pend);
            16'd1:   rv = 16'(m_en);
            16'd2:   rv = 16'(m_mode);
            16'd3:   rv = m_vbase;
            16'd4:   rv = any ? (16'h8000 | 16'(id)) : 16'h0;
            default: rv = 16'h0;
         endcase
         m_sel   = hit;
         m_rdata = hit ? rv : 16'h0;
         m_int   = any;
         if (any) m_int_addr = m_vbase + 16'(id * int'(STRIDE));
         np = m_pend;
         for (int i = 0; i < int'(NSRC); i++) begin
            if (!m_mode[i]) np[i] = s[i];
            else if ((s[i] && !sd[i]) || (wr && off == 16'd5 && wd[i])) np[i] = 1'b1;
            else if (wr && off == 16'd0 && wd[i]) np[i] = 1'b0;
         end
         m_pend = np;
         if (wr && off == 16'd1) m_en    = wd[NSRC-1:0];
         if (wr && off == 16'd2) m_mode  = wd[NSRC-1:0];
         if (wr && off == 16'd3) m_vbase = wd;
         m_hist.push_front(i_src);
         void'(m_hist.pop_back());
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_step();
      #1;
      chk("o_int",      16'(o_int),      16'(m_int));
      chk("o_int_addr", o_int_addr,      m_int_addr);
      chk("o_sel",      16'(bus.o_sel),  16'(m_sel));
      chk("o_rdata",    bus.o_rdata,     m_rdata);
   endtask

   task automatic wr(input int off, input logic [15:0] d);
      bus.i_mem_addr = BASE + 16'(off); bus.i_mem_write_data = d; bus.i_ram_we = 1'b1;
      tick();
      bus.i_ram_we = 1'b0; bus.i_mem_addr = 16'h0000;
   endtask

   task automatic rd(input int off, output logic [15:0] v);
      bus.i_mem_addr = BASE + 16'(off); bus.i_ram_we = 1'b0;
      tick();
      v = bus.o_rdata;
      chk("rd_sel", 16'(bus.o_sel), 16'h1);
      bus.i_mem_addr = 16'h0000;
   endtask

   task automatic wait_int(input logic val, input int max);
      int k = 0;
      while (o_int !== val && k < max) begin tick(); k++; end
      chk("wait_int", 16'(o_int), 16'(val));
   endtask

   initial begin
      logic [15:0] v;
      logic [15:0] rst_exp[5];
      rst_exp = '{16'h0, 16'h0, 16'h0, 16'h2100, 16'h0};
      i_rst = 1'b0; i_ce = 1'b1; i_src = '0;
      bus.i_mem_addr = 16'h0; bus.i_mem_write_data = 16'h0; bus.i_ram_we = 1'b0;

      // Reset and idle register values
      repeat (3) tick();
      i_rst = 1'b1;
      chk("rst_int", 16'(o_int), 16'h0);
      for (int i = 0; i < 5; i++) begin
         rd(i, v);
         chk("rst_rd", v, rst_exp[i]);
      end

      // Edge latch and vector
      wr(1, 16'h000C); wr(2, 16'h00FF); wr(3, 16'h3000);
      i_src = 8'h08; tick(); i_src = '0;
      wait_int(1'b1, 8);
      chk("edge_vec", o_int_addr, 16'h300C);
      rd(0, v); chk("edge_pend", v, 16'h0008);
      wr(0, 16'h0008); tick();
      chk("edge_clr", 16'(o_int), 16'h0);

      // Priority among simultaneous pending bits
      wr(5, 16'h000C); tick();
      chk("prio_vec", o_int_addr, 16'h3008);
      rd(4, v); chk("prio_act", v, 16'h8002);
      wr(0, 16'h0004); tick();
      chk("prio_vec2", o_int_addr, 16'h300C);
      rd(4, v); chk("prio_act2", v, 16'h8003);
      wr(0, 16'h0008); tick();

      // Set beats clear on the same edge
      i_src = 8'h02; tick(); tick();
      wr(0, 16'h0002);
      rd(0, v); chk("collide", 16'(v[1]), 16'h1);
      wr(0, 16'h0002); i_src = '0; repeat (3) tick();

      // Level mode
      wr(2, 16'h0000); wr(1, 16'h0001);
      i_src = 8'h01;
      wait_int(1'b1, 8);
      wr(0, 16'h0001); tick();
      chk("lvl_hold", 16'(o_int), 16'h1);
      i_src = '0;
      wait_int(1'b0, int'(SS) + 2);

      // Vector wrap, then clock-enable hold
      wr(3, 16'hFFFE); wr(2, 16'h00FF); wr(1, 16'h0002); wr(5, 16'h0002); tick();
      chk("wrap_vec", o_int_addr, 16'h0002);
      wr(0, 16'h0002); tick();
      chk("wrap_clr", 16'(o_int), 16'h0);
      i_ce = 1'b0; i_src = 8'h02;
      repeat (5) tick();
      chk("ce_hold", 16'(o_int), 16'h0);
      i_ce = 1'b1;
      wait_int(1'b1, 8);
      chk("ce_vec", o_int_addr, 16'h0002);
      i_src = '0;

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         i_rst = ($urandom_range(0, 499) != 0);
         i_ce  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 3) == 0) i_src = i_src ^ NSRC'($urandom);
         bus.i_mem_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                      : BASE + 16'($urandom_range(0, 7));
         bus.i_mem_write_data = 16'($urandom);
         bus.i_ram_we = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller that sits on the CPU data/instruction bus as a responder.
- Collects NSRC external interrupt sources and latches them as pending.
- Drives the CPU's interrupt request and jump address: o_int goes to the CPU i_int, o_int_addr goes to the CPU i_int_addr.
- Software masks, acknowledges, vectors and soft-triggers interrupts through registers at BASE..BASE+5.

Parameters:
- NSRC, 8: number of interrupt sources, 1..16.
- BASE, 16'hFF00: bus address of register 0.
- VEC_STRIDE, 4: address distance between consecutive vectors.
- SYNC_STAGES, 2: synchronizer flops per source input.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-low reset.
- i_ce  in  1  clock enable. All non-reset state updates only when i_ce=1.
- i_mem_addr  in  16  bus address from the CPU.
- i_mem_write_data  in  16  CPU write data.
- i_ram_we  in  1  CPU write strobe, one cycle.
- o_rdata  out  16  registered read data.
- o_sel  out  1  registered "o_rdata is ours" flag for the system read mux.
- i_src  in  NSRC  raw asynchronous interrupt lines, active-high.
- o_int  out  1  interrupt request to the CPU.
- o_int_addr  out  16  vector for the highest-priority active source.

Behaviour:
- Reset:
  - i_rst=0 at a clock edge clears all state, regardless of i_ce.
  - Output reset values: o_rdata=0, o_sel=0, o_int=0, o_int_addr=0.
  - Register reset values: PENDING=0, ENABLE=0, MODE=0, VBASE=16'h2100, all synchronizer and edge flops=0.
  - Reset asserted mid-operation drops o_int on the next edge.
- Synchronizer: each i_src bit passes through SYNC_STAGES flops, giving s. A further flop holds s_d for edge detect.
- Register map (offset from BASE):
  - 0 PENDING: read returns PENDING. Write is W1C, i.e. each 1 clears that bit, but edge-mode bits only.
  - 1 ENABLE: RW.
  - 2 MODE: RW. 1=rising-edge, 0=level.
  - 3 VBASE: RW, full 16 bits.
  - 4 ACTIVE: RO. [15]=any active, [3:0]=active id.
  - 5 SWSET: write-1-to-set PENDING for edge-mode bits. Reads as 0.
  - Bits at or above NSRC read 0 and ignore writes.
  - Offsets 6..255 are not decoded. No side effects, o_sel=0.
- Pending update per edge-mode bit i, each enabled cycle: set if (s[i] & ~s_d[i]) or SWSET write bit i; else clear if PENDING W1C bit i.
  - Set beats clear in the same cycle, so no edge is lost.
- Pending update per level-mode bit i: PENDING[i] = s[i] every cycle. W1C and SWSET have no effect.
  - Switching MODE from edge to level discards the latched edge.
- Active set A = PENDING & ENABLE. Priority: lowest index wins.
- Registered request outputs, one cycle after PENDING/ENABLE change:
  - o_int = |A.
  - o_int_addr = VBASE + id*VEC_STRIDE, modulo 2^16 (wraps).
  - When A=0, o_int_addr holds its last value.
- o_int stays high until software clears the source. The CPU masks internally until its return-from-interrupt, so the ISR must W1C the bit or drop the level before returning, otherwise it re-enters immediately.
- Read timing:
  - The address is sampled on the edge where i_mem_addr is in BASE..BASE+5.
  - o_rdata and o_sel are valid the following cycle. This matches the CPU's one-cycle read latency.
  - On non-matching addresses the next-cycle values are o_rdata=0 and o_sel=0.
  - Reads have no side effects.
- Write timing: effective on the edge where i_ram_we=1 and the address matches. The new value is visible to a read issued the next cycle.
- i_ce=0: all flops hold, including synchronizers, so edges are detected once i_ce returns. Outputs are stable.

Test Plan:
- Reset/idle: hold i_rst=0 for 3 cycles, then release. Read offsets 0..4. Expected: o_rdata reads 0,0,0,16'h2100,0 with o_sel=1 the cycle after each address; o_int=0.
- Edge latch and vector:
  - Write ENABLE=8'h0C, MODE=8'hFF, VBASE=16'h3000. Pulse i_src[3] for 1 cycle.
  - Expected: PENDING=8'h08 after SYNC_STAGES+1 cycles, then o_int=1 and o_int_addr=16'h300C.
  - Write 8'h08 to PENDING. Expected: o_int=0 two cycles later.
- Priority: set PENDING=8'h0C via SWSET with ENABLE=8'h0C, VBASE=16'h3000. Expected: o_int_addr=16'h3008 and ACTIVE=16'h8002. After W1C of bit 2, expected 16'h300C and 16'h8003.
- Set/clear collision: time an i_src[1] rising edge to reach PENDING on the same cycle as a W1C of bit 1. Expected: PENDING[1]=1.
- Level mode: MODE=0, ENABLE=1, hold i_src[0]=1. Expected: o_int stays 1 after a W1C write. Drop i_src[0]; expected o_int=0 within SYNC_STAGES+2 cycles.
- Wrap/CE: VBASE=16'hFFFE, id 1, stride 4. Expected: o_int_addr=16'h0002. With i_ce=0 during an i_src edge, expected no change until i_ce=1.
